// File: rtl/cpu_pkg.sv
// Shared CPU types: the 32-bit word and the instruction sequencer state encoding.
// SEQ_ERR only exists when SEQ_TIMEOUT_EN is defined.
package cpu_pkg;

    typedef logic [31:0] word_t;

    localparam int SEQ_TIMER_W = 16;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_FETCH,
        SEQ_DECODE,
        SEQ_EXEC,
        SEQ_MEM,
        SEQ_WB
`ifdef SEQ_TIMEOUT_EN
        , SEQ_ERR
`endif
    } seq_state_t;

endpackage

// File: rtl/core_sequencer.sv
// Multi-cycle instruction sequencer: steps FETCH/DECODE/EXEC/MEM/WB and runs the memory bus handshake.
// Optional bus timeout into a sticky ERR state is compiled in with SEQ_TIMEOUT_EN.
module core_sequencer
    import cpu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] pc,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic [31:0] instr,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [31:0] load_data,
    output logic        pc_en,
    output logic        wb_en,
    output logic        busy,
    output logic        err
);

    seq_state_t r_state;
    seq_state_t w_nextState;
    word_t      r_instr;
    word_t      r_loadData;

    assign instr     = r_instr;
    assign load_data = r_loadData;

    // Acks are only honoured from inside a request state, so an ack landing on entry is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= SEQ_IDLE;
            r_instr    <= '0;
            r_loadData <= '0;
        end else begin
            r_state <= w_nextState;
            if (r_state == SEQ_FETCH && bus_ack) begin
                r_instr <= bus_rdata;
            end
            if (r_state == SEQ_MEM && bus_ack && !memWrite) begin
                r_loadData <= bus_rdata;
            end
        end
    end

`ifdef SEQ_TIMEOUT_EN
    logic [SEQ_TIMER_W-1:0] r_timer;
    logic                   w_timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer <= '0;
        end else if ((r_state == SEQ_FETCH || r_state == SEQ_MEM) && !bus_ack) begin
            r_timer <= r_timer + 1'b1;
        end else begin
            r_timer <= '0;
        end
    end

    assign w_timeout = (r_state == SEQ_FETCH || r_state == SEQ_MEM) && !bus_ack &&
                       (r_timer == SEQ_TIMER_W'(TIMEOUT_CYCLES - 1));
`else
    // The timeout length only matters when the timeout logic is compiled in.
    logic w_unusedTimeoutParam;
    assign w_unusedTimeoutParam = ^TIMEOUT_CYCLES;
`endif

    always_comb begin
        w_nextState = r_state;
        bus_req     = 1'b0;
        bus_we      = 1'b0;
        bus_addr    = '0;
        bus_wdata   = '0;
        pc_en       = 1'b0;
        wb_en       = 1'b0;
        busy        = (r_state != SEQ_IDLE);
        err         = 1'b0;

        case (r_state)
            SEQ_IDLE: begin
                if (en) begin
                    w_nextState = SEQ_FETCH;
                end
            end
            SEQ_FETCH: begin
                bus_req  = 1'b1;
                bus_addr = pc;
                if (bus_ack) begin
                    w_nextState = SEQ_DECODE;
                end
`ifdef SEQ_TIMEOUT_EN
                else if (w_timeout) begin
                    w_nextState = SEQ_ERR;
                end
`endif
            end
            SEQ_DECODE: begin
                w_nextState = SEQ_EXEC;
            end
            SEQ_EXEC: begin
                w_nextState = (memRead || memWrite) ? SEQ_MEM : SEQ_WB;
            end
            SEQ_MEM: begin
                bus_req   = 1'b1;
                bus_we    = memWrite;
                bus_addr  = data_addr;
                bus_wdata = data_wdata;
                if (bus_ack) begin
                    w_nextState = SEQ_WB;
                end
`ifdef SEQ_TIMEOUT_EN
                else if (w_timeout) begin
                    w_nextState = SEQ_ERR;
                end
`endif
            end
            SEQ_WB: begin
                pc_en       = 1'b1;
                wb_en       = 1'b1;
                w_nextState = en ? SEQ_FETCH : SEQ_IDLE;
            end
`ifdef SEQ_TIMEOUT_EN
            SEQ_ERR: begin
                err = 1'b1;
            end
`endif
            default: begin
                w_nextState = SEQ_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: a per-instruction trace model builds expected cycle records,
// one loop applies them and compares every output each cycle; literal snapshots pin the model.
module tb_core_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [31:0] pc = '0;
    logic        memRead = 1'b0;
    logic        memWrite = 1'b0;
    logic [31:0] data_addr = '0;
    logic [31:0] data_wdata = '0;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic [31:0] instr;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] load_data;
    logic        pc_en;
    logic        wb_en;
    logic        busy;
    logic        err;

    core_sequencer #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .en(en), .pc(pc),
        .memRead(memRead), .memWrite(memWrite),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .instr(instr), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .load_data(load_data),
        .pc_en(pc_en), .wb_en(wb_en), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, en, memRead, memWrite, ack;
        logic [31:0] pc, daddr, wdata, rdata;
        logic        chk, chkWd;
        logic        xReq, xWe, xPcEn, xWbEn, xBusy, xErr;
        logic [31:0] xAddr, xWdata, xInstr, xLoad;
        int          tag;
    } cyc_t;

    cyc_t        q[$];
    cyc_t        c;
    logic [31:0] mInstr = '0;
    logic [31:0] mLoad = '0;
    logic        mIdle = 1'b1;
    int          checks = 0;
    int          errors = 0;
    int          pcEnAt[$];
    logic [31:0] snapInstrA, snapAddrA, snapLoadB, snapLoadC, snapLoadD;
    logic        snapBusyE;

`ifdef SEQ_TIMEOUT_EN
    localparam int EXP_PULSES = 5;
`else
    localparam int EXP_PULSES = 6;
`endif

    task automatic expDefaults();
        c.rst = 1'b0; c.ack = 1'b0; c.rdata = 32'h0; c.chk = 1'b1; c.chkWd = 1'b1;
        c.xReq = 1'b0; c.xWe = 1'b0; c.xPcEn = 1'b0; c.xWbEn = 1'b0;
        c.xBusy = 1'b0; c.xErr = 1'b0; c.xAddr = '0; c.xWdata = '0;
        c.xInstr = mInstr; c.xLoad = mLoad; c.tag = 0;
    endtask

    task automatic pushCyc();
        q.push_back(c);
    endtask

    task automatic pushIdle(input int n, input logic noisy);
        for (int k = 0; k < n; k++) begin
            expDefaults(); c.en = 1'b0; c.ack = noisy; c.rdata = 32'hBAD0_0009;
            pushCyc();
        end
    endtask

    // One instruction as seen from outside: optional IDLE entry, fetch waits, decode, exec,
    // optional data access (or abort by reset), then the writeback pulse.
    task automatic pushInstr(input logic [31:0] ipc, iword, input logic mr, mw,
                             input logic [31:0] da, wd, mrd, input int fw, mwait,
                             input logic enEx, noisy, input int abortMem);
        c.pc = ipc; c.memRead = mr; c.memWrite = mw; c.daddr = da; c.wdata = wd;
        if (mIdle) begin
            expDefaults(); c.en = 1'b1; c.ack = noisy; c.rdata = 32'hBAD0_0001;
            pushCyc();
        end
        for (int k = 0; k <= fw; k++) begin
            expDefaults(); c.en = 1'b1; c.xReq = 1'b1; c.xBusy = 1'b1;
            c.xAddr = ipc; c.chkWd = 1'b0; c.ack = (k == fw);
            c.rdata = (k == fw) ? iword : 32'hBAD0_0002;
            pushCyc();
        end
        mInstr = iword;
        expDefaults(); c.en = 1'b1; c.xBusy = 1'b1; c.ack = noisy; c.rdata = 32'hBAD0_0003;
        pushCyc();
        expDefaults(); c.en = enEx; c.xBusy = 1'b1; c.ack = noisy; c.rdata = 32'hBAD0_0004;
        pushCyc();
        if (mr || mw) begin
            for (int k = 0; k <= ((abortMem > 0) ? abortMem - 1 : mwait); k++) begin
                expDefaults(); c.en = enEx; c.xReq = 1'b1; c.xBusy = 1'b1;
                c.xAddr = da; c.xWe = mw; c.xWdata = wd;
                c.ack = (abortMem == 0) && (k == mwait);
                c.rdata = c.ack ? mrd : 32'hBAD0_0005;
                c.rst = (abortMem > 0) && (k == abortMem - 1);
                pushCyc();
            end
            if (abortMem == 0 && !mw) mLoad = mrd;
        end
        if (abortMem > 0) begin
            mInstr = '0; mLoad = '0; mIdle = 1'b1;
            expDefaults(); c.en = 1'b0; c.ack = 1'b1; c.rdata = mrd;
            pushCyc();
        end else begin
            expDefaults(); c.en = enEx; c.xPcEn = 1'b1; c.xWbEn = 1'b1; c.xBusy = 1'b1;
            c.ack = noisy; c.rdata = 32'hBAD0_0006;
            pushCyc();
            mIdle = !enEx;
        end
    endtask

    task automatic applyStimulus(input int i);
        rst = q[i].rst; en = q[i].en; pc = q[i].pc;
        memRead = q[i].memRead; memWrite = q[i].memWrite;
        data_addr = q[i].daddr; data_wdata = q[i].wdata;
        bus_ack = q[i].ack; bus_rdata = q[i].rdata;
    endtask

    task automatic checkOutput(input string nm, input int cyc, input logic [31:0] act, exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    initial begin
        int startA, startB, startC, startD, startE;

        c.pc = '0; c.memRead = 1'b0; c.memWrite = 1'b0; c.daddr = '0; c.wdata = '0;
        expDefaults(); c.rst = 1'b1; c.en = 1'b0; c.chk = 1'b0; pushCyc();
        expDefaults(); c.rst = 1'b1; c.en = 1'b0; pushCyc();
        pushIdle(2, 1'b0);

        startA = q.size();
        pushInstr(32'h10, 32'h00A00093, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 0);
        q[startA + 1].tag = 3;
        q[q.size() - 1].tag = 1;

        startB = q.size();
        pushInstr(32'h14, 32'h00002083, 1, 0, 32'h200, 32'h0, 32'hDEADBEEF, 0, 3, 1'b1, 1'b0, 0);
        q[q.size() - 1].tag = 2;

        startC = q.size();
        pushInstr(32'h18, 32'h0010A223, 0, 1, 32'h204, 32'h12345678, 32'h0BADF00D, 1, 2, 1'b1, 1'b1, 0);
        q[q.size() - 1].tag = 4;

        startD = q.size();
        pushInstr(32'h1C, 32'h0020A423, 1, 1, 32'h300, 32'hCAFEF00D, 32'h55555555, 0, 0, 1'b1, 1'b0, 0);
        q[q.size() - 1].tag = 5;

        startE = q.size();
        pushInstr(32'h20, 32'h00108113, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 0);
        pushIdle(2, 1'b1);
        q[q.size() - 2].tag = 6;

        pushInstr(32'h40, 32'h00402183, 1, 0, 32'h400, 32'h0, 32'h77777777, 0, 9, 1'b1, 1'b1, 2);
        pushIdle(1, 1'b0);

`ifdef SEQ_TIMEOUT_EN
        c.pc = 32'h44; c.memRead = 1'b0; c.memWrite = 1'b0;
        expDefaults(); c.en = 1'b1; pushCyc();
        for (int k = 0; k < 4; k++) begin
            expDefaults(); c.en = 1'b1; c.xReq = 1'b1; c.xBusy = 1'b1;
            c.xAddr = 32'h44; c.chkWd = 1'b0; pushCyc();
        end
        for (int k = 0; k < 3; k++) begin
            expDefaults(); c.en = 1'b1; c.xBusy = 1'b1; c.xErr = 1'b1;
            c.ack = (k == 1); c.rdata = 32'hBAD0_0007; pushCyc();
        end
        expDefaults(); c.en = 1'b0; c.rst = 1'b1; c.xBusy = 1'b1; c.xErr = 1'b1; pushCyc();
        mInstr = '0; mLoad = '0; mIdle = 1'b1;
        pushIdle(1, 1'b0);
`else
        pushInstr(32'h44, 32'h00000013, 0, 0, 0, 0, 0, 10, 0, 1'b0, 1'b0, 0);
`endif
        pushIdle(2, 1'b0);

        for (int i = 0; i < q.size(); i++) begin
            @(negedge clk);
            applyStimulus(i);
            #1;
            if (q[i].chk) begin
                checkOutput("bus_req",   i, {31'b0, bus_req}, {31'b0, q[i].xReq});
                checkOutput("bus_we",    i, {31'b0, bus_we},  {31'b0, q[i].xWe});
                checkOutput("bus_addr",  i, bus_addr, q[i].xAddr);
                if (q[i].chkWd) checkOutput("bus_wdata", i, bus_wdata, q[i].xWdata);
                checkOutput("pc_en",     i, {31'b0, pc_en}, {31'b0, q[i].xPcEn});
                checkOutput("wb_en",     i, {31'b0, wb_en}, {31'b0, q[i].xWbEn});
                checkOutput("busy",      i, {31'b0, busy},  {31'b0, q[i].xBusy});
                checkOutput("err",       i, {31'b0, err},   {31'b0, q[i].xErr});
                checkOutput("instr",     i, instr, q[i].xInstr);
                checkOutput("load_data", i, load_data, q[i].xLoad);
            end
            if (pc_en === 1'b1) pcEnAt.push_back(i);
            case (q[i].tag)
                1: snapInstrA = instr;
                2: snapLoadB = load_data;
                3: snapAddrA = bus_addr;
                4: snapLoadC = load_data;
                5: snapLoadD = load_data;
                6: snapBusyE = busy;
                default: ;
            endcase
        end

        // Hand-computed anchors independent of the trace model.
        checkOutput("lit_instrA", 0, snapInstrA, 32'h00A00093);
        checkOutput("lit_addrA",  0, snapAddrA,  32'h00000010);
        checkOutput("lit_loadB",  0, snapLoadB,  32'hDEADBEEF);
        checkOutput("lit_loadC",  0, snapLoadC,  32'hDEADBEEF);
        checkOutput("lit_loadD",  0, snapLoadD,  32'hDEADBEEF);
        checkOutput("lit_busyE",  0, {31'b0, snapBusyE}, 32'h0);
        checkOutput("lit_pulses", 0, pcEnAt.size(), EXP_PULSES);
        if (pcEnAt.size() >= 5) begin
            checkOutput("lit_latA", 0, pcEnAt[0] - startA, 4);
            checkOutput("lit_latB", 0, pcEnAt[1] - startB, 8);
            checkOutput("lit_latC", 0, pcEnAt[2] - startC, 7);
            checkOutput("lit_latD", 0, pcEnAt[3] - startD, 4);
            checkOutput("lit_latE", 0, pcEnAt[4] - startE, 3);
        end else begin
            checks++;
            errors++;
            $display("[TB] FAIL lit_lat: got %0d pc_en pulses expected at least 5", pcEnAt.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
